// File: rtl/apb_master_ctrl_param.sv
// Parametrised APB4 master: buffers host requests in a FIFO and issues them
// as APB transfers to NUM_SLAVES slaves, with wait states, slave errors,
// address-decode errors and an optional access timeout.
module apb_master_ctrl_param #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SLV_LSB     = 12,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_strb,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [NUM_SLAVES-1:0]   Psel,
  output logic                    Penable,
  output logic                    Pwrite,
  output logic [ADDR_W-1:0]       Paddr,
  output logic [DATA_W-1:0]       Pwdata,
  output logic [DATA_W/8-1:0]     Pstrb,
  input  logic                    Pready,
  input  logic [DATA_W-1:0]       Prdata,
  input  logic                    Pslverr
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned TO_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] f_addr  [DEPTH];
  logic [DATA_W-1:0] f_wdata [DEPTH];
  logic [STRB_W-1:0] f_strb  [DEPTH];
  logic              f_write [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop, empty;

  logic [ADDR_W-1:0]     head_addr;
  logic [SEL_W-1:0]      head_idx;
  logic                  head_bad;
  logic [NUM_SLAVES-1:0] head_onehot;

  logic [TO_W-1:0] tcnt;
  logic            timeout_hit, done;

  logic [NUM_SLAVES-1:0] psel_d;
  logic                  penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0]     paddr_d;
  logic [DATA_W-1:0]     pwdata_d, rsp_rdata_d;
  logic [STRB_W-1:0]     pstrb_d;

  assign push        = req_valid && req_ready;
  assign empty       = (count == '0);
  assign head_addr   = f_addr[rptr];
  assign head_idx    = head_addr[SLV_LSB +: SEL_W];
  assign head_bad    = (32'(head_idx) >= NUM_SLAVES);
  assign head_onehot = NUM_SLAVES'(1) << head_idx;
  assign timeout_hit = (TIMEOUT_CYC != 0) && !Pready && (tcnt == TO_W'(TO_LAST));

  // FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge Hclk) begin
    if (push) begin
      f_addr[wptr]  <= req_addr;
      f_wdata[wptr] <= req_wdata;
      f_strb[wptr]  <= req_strb;
      f_write[wptr] <= req_write;
    end
  end

  // FIFO occupancy after this edge's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count     <= count_nxt;
      req_ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // State register
  always_ff @(posedge Hclk) begin
    if (Hreset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO pop; a finishing transfer chains straight into the next entry
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:   done = 1'b0;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: done = Pready || timeout_hit;
      S_ERR:    done = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
    if (state == S_IDLE || done) begin
      if (!empty) begin
        pop       = 1'b1;
        state_nxt = head_bad ? S_ERR : S_SETUP;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // Next values of the registered APB and response outputs
  always_comb begin
    psel_d      = '0;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    paddr_d     = Paddr;
    pwrite_d    = Pwrite;
    pwdata_d    = Pwdata;
    pstrb_d     = Pstrb;
    if (pop && !head_bad) begin
      paddr_d  = head_addr;
      pwrite_d = f_write[rptr];
      pstrb_d  = f_write[rptr] ? f_strb[rptr] : '0;
      if (f_write[rptr]) pwdata_d = f_wdata[rptr];
    end
    case (state_nxt)
      S_SETUP:  psel_d = head_onehot;
      S_ACCESS: begin
        psel_d    = Psel;
        penable_d = 1'b1;
      end
      default:  psel_d = '0;
    endcase
    if (state == S_ACCESS && done) begin
      rsp_valid_d = 1'b1;
      if (Pready) begin
        rsp_err_d   = Pslverr;
        rsp_rdata_d = Pwrite ? '0 : Prdata;
      end else begin
        rsp_err_d = 1'b1;
      end
    end
    if (state == S_ERR) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Psel      <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      Psel      <= psel_d;
      Penable   <= penable_d;
      Pwrite    <= pwrite_d;
      Paddr     <= paddr_d;
      Pwdata    <= pwdata_d;
      Pstrb     <= pstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      busy      <= (count_nxt != '0) || (state_nxt != S_IDLE);
    end
  end

  // Consecutive wait-state counter, cleared whenever a new entry is popped
  always_ff @(posedge Hclk) begin
    if (Hreset)                                         tcnt <= '0;
    else if (pop)                                       tcnt <= '0;
    else if (state == S_ACCESS && !Pready && TIMEOUT_CYC != 0) tcnt <= tcnt + TO_W'(1);
  end

endmodule
